// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger burst sequencer: FSM state encoding,
// default bus widths and the pulse-count value that selects endless bursts.
package trigger_pkg;

  localparam int unsigned DEF_DW = 32;
  localparam int unsigned DEF_W  = 16;
  localparam int unsigned DEF_NW = 16;

  // A programmed pulse count of zero keeps the burst running until stop.
  localparam int unsigned NPULSE_INFINITE = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

endpackage

// File: rtl/trig_down_cnt.sv
// Loadable down-counter used to time the start delay and the high/low phases.
// The terminal-count flag is raised on the last cycle of the loaded span, and
// a load value of zero behaves like one so every span lasts at least a cycle.
module trig_down_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_cnt;

  // Load takes priority; otherwise count down, saturating at zero.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_tc = (r_cnt <= WIDTH'(1));

endmodule

// File: rtl/trigger_burst_ctrl.sv
// Counted trigger burst sequencer: optional start delay, then NPULSE pulses of
// WIDTH0 high / WIDTH1 low cycles, with abort and an endless mode.
// Burst settings are captured when a start is accepted, so register writes
// during a burst only affect the next one.
module trigger_burst_ctrl
  import trigger_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned W  = DEF_W,
  parameter int unsigned NW = DEF_NW
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          start,
  input  logic          stop,
  input  logic [DW-1:0] DELAY_REG,
  input  logic [W-1:0]  WIDTH0_REG,
  input  logic [W-1:0]  WIDTH1_REG,
  input  logic [NW-1:0] NPULSE_REG,
  output logic          trigger,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] pulse_cnt
);

  state_t        r_state;
  state_t        w_next_state;
  logic [W-1:0]  r_width0;
  logic [W-1:0]  r_width1;
  logic [NW-1:0] r_npulse;
  logic [NW-1:0] r_pulse_cnt;
  logic          r_trigger;
  logic          r_busy;
  logic          r_done;

  logic          w_accept;
  logic          w_done_next;
  logic          w_dly_tc;
  logic          w_ph_tc;
  logic          w_in_phase;
  logic          w_enter_high;
  logic          w_ph_load;
  logic [W-1:0]  w_ph_load_val;
  logic          w_last_pulse;

  assign w_accept     = (r_state == ST_IDLE) && start && !stop;
  assign w_in_phase   = (r_state == ST_HIGH) || (r_state == ST_LOW);
  assign w_last_pulse = (r_npulse != NW'(NPULSE_INFINITE)) && (r_pulse_cnt == r_npulse);
  assign w_enter_high = (w_next_state == ST_HIGH) && (r_state != ST_HIGH);

  // Reload the phase counter on every HIGH/LOW entry. A burst with no delay
  // enters HIGH straight from IDLE, before the width latch has been written.
  assign w_ph_load     = ((w_next_state == ST_HIGH) || (w_next_state == ST_LOW))
                         && (w_next_state != r_state);
  assign w_ph_load_val = (w_next_state == ST_LOW)  ? r_width1   :
                         (r_state      == ST_IDLE) ? WIDTH0_REG : r_width0;

  trig_down_cnt #(.WIDTH(DW)) u_delay_cnt (
    .i_clk      (aclk),
    .i_rst      (areset),
    .i_load     (w_accept),
    .i_load_val (DELAY_REG),
    .i_dec      (r_state == ST_DELAY),
    .o_tc       (w_dly_tc)
  );

  trig_down_cnt #(.WIDTH(W)) u_phase_cnt (
    .i_clk      (aclk),
    .i_rst      (areset),
    .i_load     (w_ph_load),
    .i_load_val (w_ph_load_val),
    .i_dec      (w_in_phase),
    .o_tc       (w_ph_tc)
  );

  // Next-state decode; stop aborts any active state and beats completion.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = (DELAY_REG != '0) ? ST_DELAY : ST_HIGH;
        end
      end
      ST_DELAY: begin
        if (stop) begin
          w_next_state = ST_IDLE;
        end else if (w_dly_tc) begin
          w_next_state = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (stop) begin
          w_next_state = ST_IDLE;
        end else if (w_ph_tc) begin
          if (w_last_pulse) begin
            w_next_state = ST_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_next_state = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        if (stop) begin
          w_next_state = ST_IDLE;
        end else if (w_ph_tc) begin
          w_next_state = ST_HIGH;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture burst settings when a start is accepted.
  // NOTE: these capture registers are reset as well, so a burst can never
  // run on power-up garbage should the FSM ever reach an active state.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_width0 <= '0;
      r_width1 <= '0;
      r_npulse <= '0;
    end else if (w_accept) begin
      r_width0 <= WIDTH0_REG;
      r_width1 <= WIDTH1_REG;
      r_npulse <= NPULSE_REG;
    end
  end

  // Pulse counter: cleared on acceptance, bumped on each HIGH entry, wraps freely.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_pulse_cnt <= '0;
    end else if (w_accept) begin
      r_pulse_cnt <= w_enter_high ? NW'(1) : '0;
    end else if (w_enter_high) begin
      r_pulse_cnt <= r_pulse_cnt + NW'(1);
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_trigger <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_trigger <= (w_next_state == ST_HIGH);
      r_busy    <= (w_next_state != ST_IDLE);
      r_done    <= w_done_next;
    end
  end

  assign trigger   = r_trigger;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_trigger_burst_ctrl.sv
// Bench for trigger_burst_ctrl: a closed-form burst model checked every cycle
// against a default-width DUT and a 4-bit pulse counter DUT, plus literal
// waveform expectations for each directed scenario.
module tb_trigger_burst_ctrl;

  localparam int DW  = 32;
  localparam int W   = 16;
  localparam int NW  = 16;
  localparam int NW4 = 4;

  logic          aclk   = 1'b0;
  logic          areset = 1'b1;
  logic          start  = 1'b0;
  logic          stop   = 1'b0;
  logic [DW-1:0] delay_reg  = '0;
  logic [W-1:0]  width0_reg = '0;
  logic [W-1:0]  width1_reg = '0;
  logic [NW-1:0] npulse_reg = '0;

  logic           trigger, busy, done;
  logic [NW-1:0]  pulse_cnt;
  logic           trigger4, busy4, done4;
  logic [NW4-1:0] pulse_cnt4;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  longint t0       = -1000;
  int     lit_id   = 0;
  int     lit_seq  = 0;
  int     lit_ack  = 0;

  trigger_burst_ctrl #(.DW(DW), .W(W), .NW(NW)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .start      (start),
    .stop       (stop),
    .DELAY_REG  (delay_reg),
    .WIDTH0_REG (width0_reg),
    .WIDTH1_REG (width1_reg),
    .NPULSE_REG (npulse_reg),
    .trigger    (trigger),
    .busy       (busy),
    .done       (done),
    .pulse_cnt  (pulse_cnt)
  );

  trigger_burst_ctrl #(.DW(DW), .W(W), .NW(NW4)) dut4 (
    .aclk       (aclk),
    .areset     (areset),
    .start      (start),
    .stop       (stop),
    .DELAY_REG  (delay_reg),
    .WIDTH0_REG (width0_reg),
    .WIDTH1_REG (width1_reg),
    .NPULSE_REG (npulse_reg[NW4-1:0]),
    .trigger    (trigger4),
    .busy       (busy4),
    .done       (done4),
    .pulse_cnt  (pulse_cnt4)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Burst model: the most recently accepted burst, described by its settings.
  bit     m_valid   = 1'b0;
  longint m_s       = 0;
  longint m_d       = 0;
  longint m_h       = 1;
  longint m_l       = 1;
  longint m_n       = 0;
  bit     m_stopped = 1'b0;
  longint m_p       = 0;

  logic [63:0] lg_trig, lg_busy, lg_done;
  longint      lg_pc  [0:63];
  longint      lg_pc4 [0:63];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Pulses issued by the time a cycle 'rel' cycles after the first rising edge ends.
  function automatic longint pulses_at(input longint rel);
    if (rel < 0) return 0;
    return rel / (m_h + m_l) + 1;
  endfunction

  // Expected outputs in cycle t from the burst's arithmetic shape.
  task automatic model_eval(input longint t, output logic et, output logic eb,
                            output logic ed, output longint ep);
    longint first, done_t, term, rel;
    et = 1'b0; eb = 1'b0; ed = 1'b0; ep = 0;
    if (!m_valid) return;
    first  = m_s + 1 + m_d;
    done_t = (m_n != 0) ? first + m_n * m_h + (m_n - 1) * m_l : 64'h7fff_ffff_ffff_ffff;
    term   = m_stopped ? m_p + 1 : done_t;
    if (t >= term) begin
      ed = !m_stopped && (m_n != 0) && (t == done_t);
      ep = pulses_at(term - 1 - first);
    end else begin
      eb = 1'b1;
      if (t >= first) begin
        rel = t - first;
        et  = (rel % (m_h + m_l)) < m_h;
        ep  = pulses_at(rel);
      end
    end
  endtask

  task automatic literal_checks(input int id);
    case (id)
      1: begin
        check("s1_trigger", 64'(lg_trig[15:0]), 64'h0738);
        check("s1_busy",    64'(lg_busy[15:0]), 64'h07FE);
        check("s1_done",    64'(lg_done[15:0]), 64'h0800);
        check("s1_pc_first", lg_pc[3], 1);
        check("s1_pc_final", lg_pc[11], 2);
      end
      2: begin
        check("s2_trigger", 64'(lg_trig[7:0]), 64'h2A);
        check("s2_busy",    64'(lg_busy[7:0]), 64'h3E);
        check("s2_done",    64'(lg_done[7:0]), 64'h40);
        check("s2_pc_final", lg_pc[6], 3);
      end
      3: begin
        check("s3_trigger", 64'(lg_trig[23:0]), 64'h0AAAAA);
        check("s3_busy",    64'(lg_busy[23:0]), 64'h1FFFFE);
        check("s3_no_done", 64'(lg_done[23:0]), 64'h0);
        check("s3_pc_hold", lg_pc[21], 10);
      end
      4: begin
        check("s4_busy_idle", 64'(lg_busy[4:0]), 64'h0);
        check("s4_pc_hold",   lg_pc[3], 10);
      end
      5: begin
        check("s5_trigger", 64'(lg_trig[6:0]), 64'h38);
        check("s5_busy",    64'(lg_busy[8:0]), 64'h07E);
        check("s5_pc_rst",  lg_pc[7], 0);
        check("s5_pc_pre",  lg_pc[5], 1);
      end
      6: begin
        check("s6_trigger",  lg_trig[41:0], 64'h00_AAAA_AAAA_AA);
        check("s6_pc4_15",   lg_pc4[29], 15);
        check("s6_pc4_wrap", lg_pc4[31], 0);
        check("s6_pc4_next", lg_pc4[33], 1);
        check("s6_pc_final", lg_pc[41], 20);
      end
      default: check("lit_id", 64'(id), 0);
    endcase
  endtask

  // Compare process: check both DUTs against the model, log, then advance the model.
  always @(negedge aclk) begin
    logic   et, eb, ed;
    longint ep, rel;
    if (areset) begin
      m_valid = 1'b0;
    end
    model_eval(cyc, et, eb, ed, ep);
    check("trigger",    64'(trigger),    64'(et));
    check("busy",       64'(busy),       64'(eb));
    check("done",       64'(done),       64'(ed));
    check("pulse_cnt",  64'(pulse_cnt),  64'(ep & 64'hFFFF));
    check("trigger4",   64'(trigger4),   64'(et));
    check("busy4",      64'(busy4),      64'(eb));
    check("done4",      64'(done4),      64'(ed));
    check("pulse_cnt4", 64'(pulse_cnt4), 64'(ep & 64'hF));

    rel = cyc - t0;
    if (rel == 0) begin
      lg_trig = '0; lg_busy = '0; lg_done = '0;
      for (int i = 0; i < 64; i++) begin
        lg_pc[i]  = 0;
        lg_pc4[i] = 0;
      end
    end
    if (rel >= 0 && rel < 64) begin
      lg_trig[rel] = trigger;
      lg_busy[rel] = busy;
      lg_done[rel] = done;
      lg_pc[rel]   = longint'(pulse_cnt);
      lg_pc4[rel]  = longint'(pulse_cnt4);
    end

    if (lit_seq != lit_ack) begin
      literal_checks(lit_id);
      lit_ack = lit_seq;
    end

    if (!areset) begin
      if (start && !stop && !eb) begin
        m_valid   = 1'b1;
        m_s       = cyc;
        m_d       = longint'(delay_reg);
        m_h       = (width0_reg == 0) ? 1 : longint'(width0_reg);
        m_l       = (width1_reg == 0) ? 1 : longint'(width1_reg);
        m_n       = longint'(npulse_reg);
        m_stopped = 1'b0;
      end else if (stop && eb) begin
        m_stopped = 1'b1;
        m_p       = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_regs(input int d, input int w0, input int w1, input int n);
    delay_reg  = DW'(d);
    width0_reg = W'(w0);
    width1_reg = W'(w1);
    npulse_reg = NW'(n);
  endtask

  // Begin a scenario: cycle 0 of the log is the cycle start is presented.
  task automatic pulse_start();
    t0    = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic request_literal(input int id);
    lit_id  = id;
    lit_seq = lit_seq + 1;
    for (int i = 0; i < 4 && lit_ack != lit_seq; i++) tick();
    if (lit_ack != lit_seq) begin
      $display("FAIL literal_handshake: scenario %0d never evaluated", id);
      $fatal(1, "literal check handshake timed out");
    end
  endtask

  initial begin
    ticks(3);
    areset = 1'b0;
    ticks(2);

    // Delay 2, 3-high/2-low, two pulses.
    set_regs(2, 3, 2, 2);
    pulse_start();
    ticks(13);
    request_literal(1);
    ticks(2);

    // Zero widths act as one cycle, no delay, three pulses.
    set_regs(0, 0, 0, 3);
    pulse_start();
    ticks(8);
    request_literal(2);
    ticks(2);

    // Endless mode, aborted in cycle 20.
    set_regs(0, 1, 1, 0);
    pulse_start();
    ticks(19);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    ticks(4);
    request_literal(3);
    ticks(2);

    // Start and stop together while idle: nothing happens, count holds.
    set_regs(2, 3, 2, 2);
    t0    = cyc;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    ticks(4);
    request_literal(4);
    ticks(2);

    // Extra start in cycle 4 is ignored.
    pulse_start();
    ticks(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(9);
    request_literal(1);
    ticks(2);

    // Width change mid-burst is ignored; reset in cycle 7 clears everything.
    pulse_start();
    ticks(3);
    width0_reg = W'(10);
    ticks(3);
    areset = 1'b1;
    ticks(2);
    areset = 1'b0;
    request_literal(5);
    ticks(2);
    set_regs(0, 0, 0, 3);
    pulse_start();
    ticks(8);
    request_literal(2);
    ticks(2);

    // Endless mode for 40 cycles: the 4-bit counter wraps mid-burst.
    set_regs(0, 1, 1, 0);
    pulse_start();
    ticks(39);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    ticks(2);
    request_literal(6);
    ticks(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
